// File: rtl/spi_shift_reg.sv
// SPI slave receive path: serial-in/parallel-out shift register that frames
// WIDTH-bit words into a holding register with a one-cycle valid strobe.
module spi_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     nReset,
    input  logic                     shiftin,
    input  logic                     enable,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         word,
    output logic                     word_valid,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_next;
    logic             frame_done;

    assign q_next     = {q[WIDTH-2:0], shiftin};
    assign frame_done = (bit_cnt == LAST_BIT);

    // q survives a dropped enable; only the bit counter restarts the frame.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            q          <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
        end else if (enable) begin
            q          <= q_next;
            word_valid <= frame_done;
            if (frame_done) begin
                word    <= q_next;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            word_valid <= 1'b0;
            bit_cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_spi_shift_reg.sv
// Directed bench for spi_shift_reg (WIDTH=16): reset, framing, hold, abort,
// back-to-back words and asynchronous reset mid-word.
module tb_spi_shift_reg;

    localparam int WIDTH = 16;

    logic             clock;
    logic             nReset;
    logic             shiftin;
    logic             enable;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic [3:0]       bit_cnt;

    int ncomp;
    int nerr;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_word;

    spi_shift_reg #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .nReset     (nReset),
        .shiftin    (shiftin),
        .enable     (enable),
        .q          (q),
        .word       (word),
        .word_valid (word_valid),
        .bit_cnt    (bit_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected summary before 500000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] ew,
                             input logic ev, input logic [3:0] ec);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".word"}, 32'(word), 32'(ew));
        chk({tag, ".valid"}, 32'(word_valid), 32'(ev));
        chk({tag, ".cnt"}, 32'(bit_cnt), 32'(ec));
    endtask

    // One clock: inputs change on the falling edge, outputs sampled 1ns after the rising edge.
    task automatic step(input logic en, input logic b);
        @(negedge clock);
        enable  = en;
        shiftin = b;
        @(posedge clock);
        #1;
    endtask

    // Sends w MSB-first from a frame start, checking every edge.
    task automatic send_word(input string tag, input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, w[WIDTH-1-i]);
            exp_q = {exp_q[WIDTH-2:0], w[WIDTH-1-i]};
            if (i == WIDTH - 1) exp_word = w;
            check_all(tag, exp_q, exp_word, (i == WIDTH - 1), 4'((i + 1) % WIDTH));
        end
    endtask

    initial begin
        ncomp    = 0;
        nerr     = 0;
        exp_q    = '0;
        exp_word = '0;
        nReset   = 1'b0;
        enable   = 1'b0;
        shiftin  = 1'b0;

        // 1. reset
        #35;
        check_all("reset", '0, '0, 1'b0, 4'd0);
        #45;
        nReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0]);
            check_all("post_reset_idle", '0, '0, 1'b0, 4'd0);
        end

        // 2. basic frame
        send_word("basic", 16'h8DF3);
        chk("basic.q_final", 32'(q), 32'h8DF3);
        chk("basic.word_final", 32'(word), 32'h8DF3);

        // 3. hold with enable low
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i[0]);
            check_all("hold", 16'h8DF3, 16'h8DF3, 1'b0, 4'd0);
        end

        // 4. abort after 5 bits, then a full frame
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i == 0 || i == 2 || i == 3));
            exp_q = {exp_q[WIDTH-2:0], (i == 0 || i == 2 || i == 3)};
            check_all("abort_partial", exp_q, 16'h8DF3, 1'b0, 4'(i + 1));
        end
        step(1'b0, 1'b1);
        check_all("abort_gap", exp_q, 16'h8DF3, 1'b0, 4'd0);
        send_word("abort_frame", 16'hA5C3);
        chk("abort.word", 32'(word), 32'hA5C3);
        step(1'b0, 1'b0);
        check_all("abort_after", 16'hA5C3, 16'hA5C3, 1'b0, 4'd0);

        // 5. back-to-back
        send_word("b2b_first", 16'h1234);
        chk("b2b.word1", 32'(word), 32'h1234);
        send_word("b2b_second", 16'hFFFF);
        chk("b2b.word2", 32'(word), 32'hFFFF);
        step(1'b0, 1'b0);
        check_all("b2b_after", 16'hFFFF, 16'hFFFF, 1'b0, 4'd0);

        // 6. async reset after 7 bits, between edges
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1);
            exp_q = {exp_q[WIDTH-2:0], 1'b1};
            check_all("pre_rst", exp_q, 16'hFFFF, 1'b0, 4'(i + 1));
        end
        @(negedge clock);
        enable = 1'b0;
        #1 nReset = 1'b0;
        #1 check_all("async_rst", '0, '0, 1'b0, 4'd0);
        #1 nReset = 1'b1;
        exp_q    = '0;
        exp_word = '0;
        step(1'b0, 1'b0);
        check_all("rst_release", '0, '0, 1'b0, 4'd0);
        send_word("post_rst", 16'h3C96);
        chk("post_rst.word", 32'(word), 32'h3C96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
        $finish;
    end

endmodule
